// File: rtl/alu_result_serializer_pkg.sv
// alu_result_serializer shared types and sizing helpers.
// Imported by the interface and the serializer top.
package alu_result_serializer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_NUM_BYTES  = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int num_bytes(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// ALU-result in / byte-stream out bundle.
// slave = serializer side, master = ALU + UART side.
interface alu_result_serializer_if
  import alu_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) ();

  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_flag;
  logic                  tx_ready;
  logic                  clr_drop;
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  busy;
  logic                  done;
  logic                  drop;

  modport slave (
    input  alu_out,
    input  alu_flag,
    input  tx_ready,
    input  clr_drop,
    output tx_data,
    output tx_valid,
    output busy,
    output done,
    output drop
  );

  modport master (
    output alu_out,
    output alu_flag,
    output tx_ready,
    output clr_drop,
    input  tx_data,
    input  tx_valid,
    input  busy,
    input  done,
    input  drop
  );

endinterface

// File: rtl/alu_result_serializer.sv
// Captures ALU results on alu_flag rise and streams them
// out as bytes over valid/ready, flagging lost results.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  alu_result_serializer_if.slave  bus
);

  localparam int NB = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int CW = cnt_width(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CW-1:0]         r_cnt;
  logic                  r_flag_d;
  logic                  r_done;
  logic                  r_drop;

  logic                  w_rise;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_load;
  logic                  w_drop_evt;
  logic                  w_tx_valid;
  logic                  w_busy;
  logic [BYTE_WIDTH-1:0] w_tx_data;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_rise     = bus.alu_flag & ~r_flag_d;
  assign w_hs       = w_tx_valid & bus.tx_ready;
  assign w_last_hs  = w_hs & (r_cnt == LAST);
  // A rise on the last handshake reloads with no gap.
  assign w_load     = w_rise & ((r_state == IDLE) | w_last_hs);
  assign w_drop_evt = w_rise & (r_state == SEND) & ~w_last_hs;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave SEND only when no new word follows.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_rise) w_state_nxt = SEND;
      SEND: if (w_last_hs && !w_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: byte at the send end of the shift register.
  always_comb begin
    w_tx_valid = (r_state == SEND);
    w_busy     = (r_state == SEND);
    if (LSB_FIRST) begin
      w_tx_data = r_shreg[BYTE_WIDTH-1:0];
      w_shifted = r_shreg >> BYTE_WIDTH;
    end else begin
      w_tx_data = r_shreg[DATA_WIDTH-1 -: BYTE_WIDTH];
      w_shifted = r_shreg << BYTE_WIDTH;
    end
  end

  // Datapath, edge detector, done pulse and sticky drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_flag_d <= 1'b0;
      r_done   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_flag_d <= bus.alu_flag;
      r_done   <= w_last_hs;
      if (w_load) begin
        r_shreg <= bus.alu_out;
        r_cnt   <= '0;
      end else if (w_hs) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_drop_evt)        r_drop <= 1'b1;
      else if (bus.clr_drop) r_drop <= 1'b0;
    end
  end

  assign bus.tx_data  = w_tx_data;
  assign bus.tx_valid = w_tx_valid;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.drop     = r_drop;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed scoreboard bench for alu_result_serializer.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_result_serializer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_result_serializer_if #(
    .DATA_WIDTH(16),
    .BYTE_WIDTH(8)
  ) bus ();

  alu_result_serializer #(
    .DATA_WIDTH(16),
    .BYTE_WIDTH(8),
    .LSB_FIRST(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         hs_cnt = 0;
  int         byte_cnt = 0;
  logic       pend_done = 1'b0;
  logic [7:0] sb[$];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    sb.push_back(w[7:0]);
    sb.push_back(w[15:8]);
  endtask

  // Scores the handshake about to happen, then advances one cycle.
  task automatic tick();
    logic hs;
    logic [7:0] e;
    chk("done", {15'd0, bus.done}, {15'd0, pend_done});
    pend_done = 1'b0;
    hs = bus.tx_valid & bus.tx_ready & ~rst;
    if (hs) begin
      hs_cnt++;
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_byte: observed %h expected none",
               bus.tx_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tx_byte", {8'd0, bus.tx_data}, {8'd0, e});
      end
      byte_cnt++;
      if (byte_cnt == 2) begin
        byte_cnt  = 0;
        pend_done = 1'b1;
      end
    end
    if (rst) begin
      sb.delete();
      byte_cnt  = 0;
      pend_done = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (bus.tx_valid !== 1'b1 && k < 4) begin
      tick();
      k++;
    end
    chk(tag, {15'd0, bus.tx_valid}, 16'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 16'(sb.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.alu_out  = '0;
    bus.alu_flag = 1'b0;
    bus.tx_ready = 1'b0;
    bus.clr_drop = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {15'd0, bus.tx_valid}, 16'd0);
    chk("rst_busy",  {15'd0, bus.busy},     16'd0);
    chk("rst_done",  {15'd0, bus.done},     16'd0);
    chk("rst_drop",  {15'd0, bus.drop},     16'd0);
    chk("rst_data",  {8'd0, bus.tx_data},   16'd0);
    rst = 1'b0;
    tick();

    // basic send
    bus.alu_out  = 16'hA55A;
    bus.alu_flag = 1'b1;
    bus.tx_ready = 1'b1;
    push_word(16'hA55A);
    tick();
    bus.alu_flag = 1'b0;
    wait_valid("t1_valid");
    chk("t1_first", {8'd0, bus.tx_data}, 16'h005A);
    drain("t1_drain");
    tick();
    chk("t1_busy", {15'd0, bus.busy}, 16'd0);

    // backpressure
    hs_cnt = 0;
    bus.tx_ready = 1'b0;
    bus.alu_out  = 16'h1234;
    bus.alu_flag = 1'b1;
    push_word(16'h1234);
    tick();
    bus.alu_flag = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_v", {15'd0, bus.tx_valid}, 16'd1);
      chk("t2_hold_d", {8'd0, bus.tx_data}, 16'h0034);
      tick();
    end
    bus.tx_ready = 1'b1;
    drain("t2_drain");
    tick();
    chk("t2_hs", 16'(hs_cnt), 16'd2);
    chk("t2_idle", {15'd0, bus.tx_valid}, 16'd0);

    // held flag
    hs_cnt = 0;
    bus.alu_out  = 16'h00FF;
    bus.alu_flag = 1'b1;
    push_word(16'h00FF);
    for (int i = 0; i < 20; i++) tick();
    bus.alu_flag = 1'b0;
    tick();
    chk("t3_hs",    16'(hs_cnt), 16'd2);
    chk("t3_sb",    16'(sb.size()), 16'd0);
    chk("t3_drop",  {15'd0, bus.drop}, 16'd0);
    chk("t3_valid", {15'd0, bus.tx_valid}, 16'd0);

    // drop while stalled
    bus.tx_ready = 1'b0;
    bus.alu_out  = 16'h1111;
    bus.alu_flag = 1'b1;
    push_word(16'h1111);
    tick();
    bus.alu_flag = 1'b0;
    wait_valid("t4_valid");
    tick();
    bus.alu_out  = 16'hBEEF;
    bus.alu_flag = 1'b1;
    tick();
    bus.alu_flag = 1'b0;
    tick();
    chk("t4_drop", {15'd0, bus.drop}, 16'd1);
    chk("t4_stall", {8'd0, bus.tx_data}, 16'h0011);
    hs_cnt = 0;
    bus.tx_ready = 1'b1;
    drain("t4_drain");
    tick();
    chk("t4_hs", 16'(hs_cnt), 16'd2);
    chk("t4_sticky", {15'd0, bus.drop}, 16'd1);
    bus.clr_drop = 1'b1;
    tick();
    bus.clr_drop = 1'b0;
    chk("t4_clr", {15'd0, bus.drop}, 16'd0);

    // clear coinciding with a new drop
    bus.tx_ready = 1'b0;
    bus.alu_out  = 16'h2222;
    bus.alu_flag = 1'b1;
    push_word(16'h2222);
    tick();
    bus.alu_flag = 1'b0;
    wait_valid("t4b_valid");
    tick();
    bus.alu_out  = 16'h3333;
    bus.alu_flag = 1'b1;
    bus.clr_drop = 1'b1;
    tick();
    bus.alu_flag = 1'b0;
    bus.clr_drop = 1'b0;
    chk("t4b_setwins", {15'd0, bus.drop}, 16'd1);
    bus.tx_ready = 1'b1;
    drain("t4b_drain");
    tick();
    bus.clr_drop = 1'b1;
    tick();
    bus.clr_drop = 1'b0;
    chk("t4b_clr", {15'd0, bus.drop}, 16'd0);

    // back-to-back
    bus.tx_ready = 1'b1;
    bus.alu_out  = 16'h1234;
    bus.alu_flag = 1'b1;
    push_word(16'h1234);
    tick();
    bus.alu_flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.tx_valid === 1'b1 && bus.tx_data === 8'h12) break;
      tick();
    end
    chk("t5_sync", {8'd0, bus.tx_data}, 16'h0012);
    bus.alu_out  = 16'hCAFE;
    bus.alu_flag = 1'b1;
    push_word(16'hCAFE);
    tick();
    bus.alu_flag = 1'b0;
    chk("t5_done",  {15'd0, bus.done},     16'd1);
    chk("t5_valid", {15'd0, bus.tx_valid}, 16'd1);
    chk("t5_busy",  {15'd0, bus.busy},     16'd1);
    chk("t5_data",  {8'd0, bus.tx_data},   16'h00FE);
    chk("t5_drop",  {15'd0, bus.drop},     16'd0);
    drain("t5_drain");
    tick();
    chk("t5_idle", {15'd0, bus.tx_valid}, 16'd0);

    // reset mid-transfer
    bus.alu_out  = 16'hDEAD;
    bus.alu_flag = 1'b1;
    push_word(16'hDEAD);
    tick();
    bus.alu_flag = 1'b0;
    wait_valid("t6_valid");
    chk("t6_first", {8'd0, bus.tx_data}, 16'h00AD);
    tick();
    chk("t6_second", {8'd0, bus.tx_data}, 16'h00DE);
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    tick();
    chk("t6_valid0", {15'd0, bus.tx_valid}, 16'd0);
    chk("t6_busy0",  {15'd0, bus.busy},     16'd0);
    chk("t6_drop0",  {15'd0, bus.drop},     16'd0);
    chk("t6_done0",  {15'd0, bus.done},     16'd0);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_de", {15'd0, bus.tx_valid}, 16'd0);
      tick();
    end

    chk("final_sb", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
